// File: rtl/a2bus_pkg.sv
// Shared constants and state encoding for the Apple II slot-bus initiator.
package a2bus_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} a2_state_e;

    localparam a2_state_e   S_LAST_NORM = S6;
    localparam a2_state_e   S_LAST_LONG = S7;
    localparam int          LONG_PERIOD = 65;

    localparam logic [11:0] DEVSEL_BASE = 12'hC08;
    localparam logic [7:0]  IOSEL_BASE  = 8'hC0;
    localparam logic [4:0]  IOSTRB_HI   = 5'b11001;

endpackage

// File: rtl/a2bus_slot_decode.sv
// Raw (unqualified, active-high) slot select decode of the upper address bits.
module a2bus_slot_decode
    import a2bus_pkg::*;
#(
    parameter int SLOT = 1
) (
    input  logic [15:4] i_a,
    output logic        o_devsel,
    output logic        o_iosel,
    output logic        o_iostrb
);

    assign o_devsel = (i_a[15:4]  == DEVSEL_BASE + 12'(SLOT));
    assign o_iosel  = (i_a[15:8]  == IOSEL_BASE + 8'(SLOT));
    assign o_iostrb = (i_a[15:11] == IOSTRB_HI);

endmodule

// File: rtl/a2bus_master.sv
// Apple II slot-bus initiator: derives PHI1/PHI0/Q3 from C7M and runs one
// 6502-style bus cycle per accepted request, capturing read data at cycle end.
module a2bus_master
    import a2bus_pkg::*;
#(
    parameter int          SLOT       = 1,
    parameter int          RES_CYCLES = 4,
    parameter int          LONG_CYCLE = 1,
    parameter logic [15:0] IDLE_ADDR  = 16'hFFFF
) (
    input  logic        C7M,
    input  logic        RES,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        PHI0,
    output logic        PHI1,
    output logic        Q3,
    output logic [15:0] A,
    output logic        nWE,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB,
    output logic        nRES
);

    localparam int CYC_W  = 7;
    localparam int RCNT_W = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;

    if (SLOT < 1 || SLOT > 7) begin : g_bad_slot
        $error("a2bus_master: SLOT must be in 1..7");
    end
    if (RES_CYCLES < 1) begin : g_bad_res
        $error("a2bus_master: RES_CYCLES must be at least 1");
    end

    a2_state_e          r_s, w_s_nxt;
    logic [CYC_W-1:0]   r_cyc;
    logic [RCNT_W-1:0]  r_rcnt;
    logic               r_nres, r_busy, r_ready, r_rsp_valid;
    logic               r_phi1, r_phi0, r_q3, r_nwe, r_doe;
    logic               r_ndev, r_nio, r_nstrb;
    logic [15:0]        r_a;
    logic [7:0]         r_dout, r_rdata;
    logic               w_long, w_last, w_pre_last, w_phi0_nxt, w_accept;
    logic               w_dev, w_io, w_strb;

    a2bus_slot_decode #(.SLOT(SLOT)) u_dec (
        .i_a      (r_a[15:4]),
        .o_devsel (w_dev),
        .o_iosel  (w_io),
        .o_iostrb (w_strb)
    );

    always_ff @(posedge C7M) begin
        if (RES) r_s <= S0;
        else     r_s <= w_s_nxt;
    end

    always_comb begin
        w_long     = 1'b0;
        w_last     = 1'b0;
        w_pre_last = 1'b0;
        w_s_nxt    = S0;
        w_long     = (LONG_CYCLE != 0) && (r_cyc == CYC_W'(LONG_PERIOD - 1));
        w_last     = (r_s == (w_long ? S_LAST_LONG : S_LAST_NORM));
        w_pre_last = (r_s == (w_long ? S6 : S5));
        if (!w_last) w_s_nxt = a2_state_e'(r_s + 3'd1);
        w_phi0_nxt = (w_s_nxt >= S3);
        // r_ready is only ever set in the last state, so this is last-state acceptance
        w_accept   = req_valid && r_ready;
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            r_cyc       <= '0;
            r_rcnt      <= '0;
            r_nres      <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_phi1      <= 1'b1;
            r_phi0      <= 1'b0;
            r_q3        <= 1'b1;
            r_a         <= IDLE_ADDR;
            r_nwe       <= 1'b1;
            r_dout      <= '0;
            r_doe       <= 1'b0;
            r_ndev      <= 1'b1;
            r_nio       <= 1'b1;
            r_nstrb     <= 1'b1;
        end else begin
            r_phi1      <= (w_s_nxt <= S2);
            r_phi0      <= w_phi0_nxt;
            r_q3        <= (w_s_nxt inside {S0, S1, S3, S4});
            r_ready     <= w_pre_last && r_nres;
            r_rsp_valid <= 1'b0;
            if (w_last) begin
                r_cyc <= (r_cyc == CYC_W'(LONG_PERIOD - 1)) ? '0 : r_cyc + CYC_W'(1);
                if (!r_nres) begin
                    if (r_rcnt == RCNT_W'(RES_CYCLES - 1)) r_nres <= 1'b1;
                    else                                   r_rcnt <= r_rcnt + RCNT_W'(1);
                end
                r_rsp_valid <= r_busy;
                if (r_busy && r_nwe) r_rdata <= D_in;
                r_busy <= w_accept;
                if (w_accept) begin
                    r_a   <= req_addr;
                    r_nwe <= ~req_we;
                    if (req_we) r_dout <= req_wdata;
                end else begin
                    r_a   <= IDLE_ADDR;
                    r_nwe <= 1'b1;
                end
            end
            // A is stable from S3 on, so decoding the current address is exact
            r_ndev  <= ~(w_phi0_nxt && w_dev);
            r_nio   <= ~(w_phi0_nxt && w_io);
            r_nstrb <= ~(w_phi0_nxt && w_strb);
            r_doe   <= (w_s_nxt >= S4) && !r_nwe;
        end
    end

    assign req_ready = r_ready & ~RES;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign PHI0      = r_phi0;
    assign PHI1      = r_phi1;
    assign Q3        = r_q3;
    assign A         = r_a;
    assign nWE       = r_nwe;
    assign D_out     = r_dout;
    assign D_oe      = r_doe;
    assign nDEVSEL   = r_ndev;
    assign nIOSEL    = r_nio;
    assign nIOSTRB   = r_nstrb;
    assign nRES      = r_nres;

endmodule

// File: tb/tb_a2bus_master.sv
// Self-checking bench for a2bus_master: vector table of single bus cycles plus
// hand sequences for reset release, back-to-back, long cycle and mid-cycle reset.
module tb_a2bus_master;

    logic        C7M, RES, req_valid, req_ready, req_we, rsp_valid;
    logic        PHI0, PHI1, Q3, nWE, D_oe, nDEVSEL, nIOSEL, nIOSTRB, nRES;
    logic [15:0] req_addr, A;
    logic [7:0]  req_wdata, rsp_rdata, D_out, D_in;

    int          n_chk = 0;
    int          n_fail = 0;
    int          tclk = 0;
    logic [7:0]  last_rd = 8'h00;
    logic [7:0]  sb[$];
    time         rsp_t[$];

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic [2:0]  sel;   // expected {devsel, iosel, iostrb} active during PHI0
    } vec_t;
    vec_t tbl[12];

    a2bus_master #(.SLOT(3), .RES_CYCLES(4), .LONG_CYCLE(1), .IDLE_ADDR(16'hFFFF)) dut (
        .C7M(C7M), .RES(RES), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .PHI0(PHI0), .PHI1(PHI1), .Q3(Q3), .A(A), .nWE(nWE),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB), .nRES(nRES)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    // clocks since reset release; state = tclk%7 for the first 64 bus cycles
    always @(posedge C7M) tclk <= RES ? 0 : tclk + 1;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h29;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge C7M) begin
        if (rsp_valid) begin
            rsp_t.push_back($time);
            if (sb.size() == 0) chk("unexpected_rsp_valid", 1, 0);
            else                chk("rsp_rdata", rsp_rdata, sb.pop_front());
        end
    end

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge C7M);
            n++;
        end while (!req_ready && n < bound);
        chk("req_ready_wait", req_ready, 1);
    endtask

    task automatic issue(input logic [15:0] addr, input logic we, input logic [7:0] wd);
        req_addr  = addr;
        req_we    = we;
        req_wdata = wd;
        req_valid = 1'b1;
        if (!we) last_rd = mem(addr);
        sb.push_back(last_rd);
    endtask

    // entered #1 after the edge that starts S0; returns at the negedge of the last state
    task automatic run_cycle(input logic [15:0] addr, input logic we, input logic [7:0] wd,
                             input logic [2:0] sel, input int last);
        for (int k = 0; k <= last; k++) begin
            D_in = (k == last) ? mem(addr) : ~mem(addr);
            @(negedge C7M);
            chk("PHI1", PHI1, k <= 2);
            chk("PHI0", PHI0, k >= 3);
            chk("Q3", Q3, (k == 0 || k == 1 || k == 3 || k == 4));
            chk("A", A, addr);
            chk("nWE", nWE, !we);
            chk("nDEVSEL", nDEVSEL, !(k >= 3 && sel[2]));
            chk("nIOSEL", nIOSEL, !(k >= 3 && sel[1]));
            chk("nIOSTRB", nIOSTRB, !(k >= 3 && sel[0]));
            chk("D_oe", D_oe, we && k >= 4);
            if (we && k >= 4) chk("D_out", D_out, wd);
            chk("req_ready", req_ready, k == last);
            if (k < last) begin
                @(posedge C7M);
                #1;
            end
        end
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{16'hC0B3, 1'b0, 8'h00, 3'b100};
        tbl[1]  = '{16'hC300, 1'b1, 8'hA5, 3'b010};
        tbl[2]  = '{16'hC0B0, 1'b1, 8'h3C, 3'b100};
        tbl[3]  = '{16'hC3FF, 1'b0, 8'h00, 3'b010};
        tbl[4]  = '{16'hC800, 1'b1, 8'h11, 3'b001};
        tbl[5]  = '{16'hC0A3, 1'b0, 8'h00, 3'b000};
        tbl[6]  = '{16'hC200, 1'b0, 8'h00, 3'b000};
        tbl[7]  = '{16'hC7FF, 1'b0, 8'h00, 3'b000};
        tbl[8]  = '{16'hD000, 1'b0, 8'h00, 3'b000};
        tbl[9]  = '{16'hC0BF, 1'b0, 8'h00, 3'b100};
        tbl[10] = '{16'hCFFF, 1'b1, 8'h5E, 3'b001};
        tbl[11] = '{16'h0000, 1'b0, 8'h00, 3'b000};

        RES = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; D_in = '0;

        // reset values and nRES release timing
        @(negedge C7M);
        @(negedge C7M);
        chk("rst_PHI1", PHI1, 1);  chk("rst_PHI0", PHI0, 0);   chk("rst_Q3", Q3, 1);
        chk("rst_A", A, 16'hFFFF); chk("rst_nWE", nWE, 1);     chk("rst_D_oe", D_oe, 0);
        chk("rst_D_out", D_out, 0); chk("rst_sel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
        chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_req_ready", req_ready, 0); chk("rst_nRES", nRES, 0);
        @(posedge C7M);
        #1 RES = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge C7M);
            if (nRES) break;
            cnt++;
        end
        chk("nRES_low_clocks", cnt, 28);
        wait_ready(30);
        chk("first_ready_clock", tclk, 34);

        // single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            if (i != 0) wait_ready(30);
            issue(tbl[i].addr, tbl[i].we, tbl[i].wd);
            @(posedge C7M);
            #1 req_valid = 1'b0;
            run_cycle(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].sel, 6);
        end

        // back-to-back reads with req_valid held
        wait_ready(30);
        rsp_t.delete();
        issue(16'hCFFF, 1'b0, 8'h00);
        @(posedge C7M);
        #1 issue(16'hC800, 1'b0, 8'h00);
        run_cycle(16'hCFFF, 1'b0, 8'h00, 3'b001, 6);
        @(posedge C7M);
        #1 req_valid = 1'b0;
        run_cycle(16'hC800, 1'b0, 8'h00, 3'b001, 6);
        repeat (2) @(posedge C7M);
        #1;
        chk("b2b_rsp_count", rsp_t.size(), 2);
        if (rsp_t.size() == 2) chk("b2b_rsp_spacing", 32'(rsp_t[1] - rsp_t[0]), 70);

        // long bus cycle 64, followed by a normal-length cycle
        cnt = 0;
        while (tclk != 63 * 7 + 6 && cnt < 80) begin
            wait_ready(30);
            cnt++;
        end
        chk("reach_cycle63", tclk, 63 * 7 + 6);
        issue(16'hC0B5, 1'b0, 8'h00);
        @(posedge C7M);
        #1 req_valid = 1'b0;
        run_cycle(16'hC0B5, 1'b0, 8'h00, 3'b100, 7);
        issue(16'hC0B6, 1'b0, 8'h00);
        @(posedge C7M);
        #1 req_valid = 1'b0;
        run_cycle(16'hC0B6, 1'b0, 8'h00, 3'b100, 6);

        // reset in S4 of a write: dropped, never completes
        wait_ready(30);
        req_addr = 16'hC300; req_we = 1'b1; req_wdata = 8'h77; req_valid = 1'b1;
        @(posedge C7M);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge C7M);
        #1;
        @(negedge C7M);
        chk("mid_D_oe_S4", D_oe, 1);
        RES = 1'b1;
        @(posedge C7M);
        #1 last_rd = 8'h00;
        @(negedge C7M);
        chk("mid_D_oe", D_oe, 0);
        chk("mid_sel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
        chk("mid_nRES", nRES, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_rdata", rsp_rdata, 0);
        repeat (2) @(posedge C7M);
        #1 RES = 1'b0;
        wait_ready(60);
        issue(16'hC3FF, 1'b0, 8'h00);
        @(posedge C7M);
        #1 req_valid = 1'b0;
        run_cycle(16'hC3FF, 1'b0, 8'h00, 3'b010, 6);
        repeat (3) @(posedge C7M);
        #1;
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
